// File: rtl/credit_link_pkg.sv
// Shared constants and types for the credit-based link (sender and receiver).
package credit_link_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DEPTH      = 4;

  typedef logic [DEF_DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/credit_link_if.sv
// Credit link bundle: sender-side flit path plus consumer-side valid/ready path.
//
// Handshake semantics:
//   - in_valid carries no back-pressure; the sender only raises it after
//     spending one credit. credit_return pulses for one cycle per freed entry.
//   - out_valid/out_ready is strict valid/ready: a transfer happens on a rising
//     clk edge where both are high; out_data is stable while out_valid is high
//     and out_ready is low.
interface credit_link_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  credit_return;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // Environment view: sender plus consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  credit_return, out_valid, out_data
  );

  // Receiver view.
  modport slave (
    input  in_valid, in_data, out_ready,
    output credit_return, out_valid, out_data
  );
endinterface

// File: rtl/credit_link_fifo.sv
// First-word fall-through buffer with power-of-two depth. Push/pop strobes
// arrive already qualified by the parent; pointers wrap modulo DEPTH.
module credit_link_fifo
  import credit_link_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; natural wrap since DEPTH is 2**PTR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Head entry is presented combinationally; zero while empty.
  always_comb begin
    rd_data = '0;
    if (occupancy != '0) begin
      rd_data = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/credit_link_rx.sv
// Receiver end of a credit-based link: buffers flits, returns one credit per
// consumed flit and counts accepted flits.
// Optional feature: define CREDIT_LINK_RX_OVF_CHECK_EN to add a sticky ovf_err
// output flagging flits that arrived with no free entry.
module credit_link_rx
  import credit_link_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  credit_link_if.slave     link,
  output logic [CNT_W-1:0] occupancy,
  output logic [31:0]      rx_total
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  ,
  output logic             ovf_err
`endif
);

  logic        push;
  logic        pop;
  logic        full;
  logic        credit_q;
  logic [31:0] rx_total_q;

  assign full           = (occupancy == CNT_W'(DEPTH));
  assign link.out_valid = (occupancy != '0);
  assign pop            = link.out_valid && link.out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push           = link.in_valid && (!full || pop);

  credit_link_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wr_data   (link.in_data),
    .rd_data   (link.out_data),
    .occupancy (occupancy)
  );

  // One registered credit pulse per pop; back-to-back pops give back-to-back pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= 1'b0;
    end else begin
      credit_q <= pop;
    end
  end

  assign link.credit_return = credit_q;

  // Accepted-flit counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_total_q <= '0;
    end else if (push) begin
      rx_total_q <= rx_total_q + 32'd1;
    end
  end

  assign rx_total = rx_total_q;

`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  logic ovf_q;

  // Sticky flag: sender overran its credits and a flit was dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (link.in_valid && full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_credit_link_rx.sv
// Self-checking bench for credit_link_rx with a reference model and an
// expected-data queue. Build with CREDIT_LINK_RX_OVF_CHECK_EN to cover ovf_err.
module tb_credit_link_rx;
  import credit_link_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  credit_link_if #(.DATA_WIDTH(DW)) link_if ();

  logic [CNT_W-1:0] occupancy;
  logic [31:0]      rx_total;
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  logic             ovf_err;
`endif

  credit_link_rx #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (link_if.slave),
    .occupancy (occupancy),
    .rx_total  (rx_total)
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    ,
    .ovf_err   (ovf_err)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            model_occ = 0;
  logic [31:0]   model_total = '0;
  bit            model_pop_prev = 1'b0;
  bit            model_ovf = 1'b0;
  int            credits = DEPTH;
  int            credit_seen = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    model_occ      = 0;
    model_total    = '0;
    model_pop_prev = 1'b0;
    model_ovf      = 1'b0;
  endfunction

  // ---------------- monitor: compare then advance model ----------------
  bit            pop_m;
  bit            push_m;
  logic [DW-1:0] exp_d;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("out_valid", 64'(link_if.out_valid), 64'(model_occ != 0));
      check("occupancy", 64'(occupancy), 64'(model_occ));
      check("credit_return", 64'(link_if.credit_return), 64'(model_pop_prev));
      check("rx_total", 64'(rx_total), 64'(model_total));
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
      check("ovf_err", 64'(ovf_err), 64'(model_ovf));
`endif
      if (link_if.credit_return === 1'b1) begin
        credits++;
        credit_seen++;
      end
      pop_m = (model_occ != 0) && (link_if.out_ready === 1'b1);
      if (pop_m) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_d = exp_q.pop_front();
          check("out_data", link_if.out_data, exp_d);
        end
      end else if (model_occ == 0) begin
        check("out_data_empty", link_if.out_data, 64'd0);
      end
      push_m = (link_if.in_valid === 1'b1) && ((model_occ < DEPTH) || pop_m);
      if ((link_if.in_valid === 1'b1) && (model_occ == DEPTH) && !pop_m) begin
        model_ovf = 1'b1;
      end
      if (push_m) begin
        exp_q.push_back(link_if.in_data);
        model_total = model_total + 32'd1;
      end
      model_occ      = model_occ + int'(push_m) - int'(pop_m);
      model_pop_prev = pop_m;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r);
    @(posedge clk);
    #1;
    link_if.in_valid  = v;
    link_if.in_data   = d;
    link_if.out_ready = r;
  endtask

  // Credit-respecting sender with a consumer toggling out_ready every cycle.
  task automatic stream(input int n);
    int   sent;
    int   guard;
    bit   r;
    int   start_seen;
    sent       = 0;
    guard      = 0;
    r          = 1'b0;
    start_seen = credit_seen;
    while (sent < n && guard < 200) begin
      @(posedge clk);
      #1;
      r = !r;
      link_if.out_ready = r;
      if (credits > 0) begin
        link_if.in_valid = 1'b1;
        link_if.in_data  = DW'($urandom_range(0, 32'hFFFF)) << 16 | DW'(sent);
        credits--;
        sent++;
      end else begin
        link_if.in_valid = 1'b0;
      end
      guard++;
    end
    check("stream_sent", 64'(sent), 64'(n));
    repeat (14) cycle(1'b0, '0, 1'b1);
    check("stream_credits", 64'(credit_seen - start_seen), 64'(n));
    check("stream_drained", 64'(occupancy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n             = 1'b0;
    link_if.in_valid  = 1'b0;
    link_if.in_data   = '0;
    link_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(link_if.out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_rx_total", 64'(rx_total), 64'd0);
    check("rst_credit", 64'(link_if.credit_return), 64'd0);
    check("rst_out_data", link_if.out_data, 64'd0);

    // Single flit; accepted on the first edge after reset release.
    @(posedge clk);
    #1;
    rst_n             = 1'b1;
    mon_en            = 1'b1;
    link_if.in_valid  = 1'b1;
    link_if.in_data   = 64'hDEEDABBA_CAFEFACE;
    link_if.out_ready = 1'b1;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("single_rx_total", 64'(rx_total), 64'd1);

    // Fill to DEPTH, then overrun once.
    for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("full_occupancy", 64'(occupancy), 64'(DEPTH));
    check("drop_rx_total", 64'(rx_total), 64'd5);

    // Simultaneous push and pop at full, then drain 2,3,4,9.
    cycle(1'b1, DW'(9), 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Reset with three flits buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(20 + i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_out_valid", 64'(link_if.out_valid), 64'd0);
    check("midrst_occupancy", 64'(occupancy), 64'd0);
    check("midrst_out_data", link_if.out_data, 64'd0);
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    check("midrst_ovf_err", 64'(ovf_err), 64'd0);
`endif
    @(posedge clk);
    #1;
    check("midrst_credit", 64'(link_if.credit_return), 64'd0);
    rst_n   = 1'b1;
    credits = DEPTH;

    // Ten flits through the wrap with a flaky consumer.
    stream(10);

    // Counter wrap.
    @(posedge clk);
    #3;
    force dut.rx_total_q = 32'hFFFF_FFFE;
    model_total = 32'hFFFF_FFFE;
    #1;
    release dut.rx_total_q;
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(40 + i), 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1);
    check("wrap_rx_total", 64'(rx_total), 64'd1);

    // Random traffic, bounded by the sender's credits.
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      link_if.out_ready = 1'($urandom_range(0, 1));
      if (credits > 0 && $urandom_range(0, 3) != 0) begin
        link_if.in_valid = 1'b1;
        link_if.in_data  = {32'($urandom), 32'($urandom)};
        credits--;
      end else begin
        link_if.in_valid = 1'b0;
      end
    end
    repeat (10) cycle(1'b0, '0, 1'b1);
    check("final_empty", 64'(occupancy), 64'd0);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
